// File: rtl/mezclador_pkg.sv
// Shared definitions for the three-band mixer/DAC serializer:
// default widths, FSM state encoding and saturation limit helpers.
// Optional feature macro used by this codebase: MEZCLADOR_ROUND_EN.
package mezclador_pkg;

  localparam int DW_DEF    = 23;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    END   = 2'd3
  } state_t;

  // Largest positive value representable in a dw-bit signed sample.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a dw-bit signed sample.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mezclador_if.sv
// Serial DAC bus: bit clock, active-low chip select and MSB-first data.
interface mezclador_if;
  logic sclk;
  logic cs_n;
  logic sdo;

  modport master (output sclk, cs_n, sdo);
  modport slave  (input  sclk, cs_n, sdo);
endinterface

// File: rtl/mezclador_serializador_spi.sv
// serializador_spi: loads one OUT_W-bit word and shifts it out MSB-first.
// dac_sclk idles low, toggles every CLK_DIV cycles; data changes only on
// falling edges so it is stable at every rising edge. o_done is high in
// the cycle whose edge produces the last falling edge of the frame.
module serializador_spi
  import mezclador_pkg::*;
#(
  parameter int OUT_W   = OUT_W_DEF,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_word,
  output logic             o_done,
  mezclador_if.master      bus
);

  localparam int L_CW = cnt_w(CLK_DIV);
  localparam int L_BW = cnt_w(OUT_W);

  logic [OUT_W-1:0] r_sh;
  logic [L_CW-1:0]  r_div;
  logic [L_BW-1:0]  r_bits;
  logic             r_sclk;
  logic             r_cs_n;
  logic             w_tick;
  logic             w_fall;

  assign w_tick = !r_cs_n && (r_div == L_CW'(CLK_DIV - 1));
  assign w_fall = w_tick && r_sclk;
  assign o_done = w_fall && (r_bits == L_BW'(OUT_W - 1));

  assign bus.sclk = r_sclk;
  assign bus.cs_n = r_cs_n;
  assign bus.sdo  = !r_cs_n && r_sh[OUT_W-1];

  // Frame engine: divider, sclk toggle, shift on falling edge, bit count.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_div  <= '0;
      r_bits <= '0;
      r_sclk <= 1'b0;
      r_cs_n <= 1'b1;
    end else if (i_load) begin
      r_sh   <= i_word;
      r_div  <= '0;
      r_bits <= '0;
      r_sclk <= 1'b0;
      r_cs_n <= 1'b0;
    end else if (!r_cs_n) begin
      r_div <= w_tick ? '0 : r_div + L_CW'(1);
      if (w_tick) r_sclk <= !r_sclk;
      if (w_fall) begin
        r_sh   <= r_sh << 1;
        r_bits <= r_bits + L_BW'(1);
      end
      if (o_done) begin
        r_cs_n <= 1'b1;
        r_bits <= '0;
      end
    end
  end

endmodule

// File: rtl/mezclador_dac.sv
// mezclador_dac: captures three signed band samples with per-band
// attenuation, sums and saturates them, and sends the top OUT_W bits of
// the result to a serial DAC. Defining MEZCLADOR_ROUND_EN adds a
// round-half-up offset before saturation; otherwise the word is truncated.
module mezclador_dac
  import mezclador_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int CLK_DIV = 2
) (
  input  logic          clock_In,
  input  logic          Reset,
  input  logic          enable,
  input  logic [DW-1:0] Data_In_bajos,
  input  logic [DW-1:0] Data_In_medios,
  input  logic [DW-1:0] Data_In_altos,
  input  logic [1:0]    gain_bajos,
  input  logic [1:0]    gain_medios,
  input  logic [1:0]    gain_altos,
  output logic          busy,
  output logic          overrun,
  output logic          done,
  output logic          dac_sclk,
  output logic          dac_cs_n,
  output logic          dac_sdo
);

  localparam int L_SW = DW + 2;
  localparam int L_CW = cnt_w(CLK_DIV);
  localparam logic signed [L_SW-1:0] L_SAT_MAX = L_SW'(sat_max(DW));
  localparam logic signed [L_SW-1:0] L_SAT_MIN = L_SW'(sat_min(DW));

  state_t                  r_state, w_next;
  logic [DW-1:0]           r_b, r_m, r_a;
  logic [1:0]              r_gb, r_gm, r_ga;
  logic [L_CW-1:0]         r_end_cnt;
  logic                    r_done;
  logic                    r_overrun;
  logic                    w_end_last;
  logic                    w_ser_done;
  logic signed [L_SW-1:0]  w_b_sh, w_m_sh, w_a_sh, w_sum, w_sat;
  logic [OUT_W-1:0]        w_word;

  mezclador_if u_dac_bus ();

  // Attenuate each band after sign-extending to the sum width.
  assign w_b_sh = $signed({{2{r_b[DW-1]}}, r_b}) >>> r_gb;
  assign w_m_sh = $signed({{2{r_m[DW-1]}}, r_m}) >>> r_gm;
  assign w_a_sh = $signed({{2{r_a[DW-1]}}, r_a}) >>> r_ga;

`ifdef MEZCLADOR_ROUND_EN
  localparam logic signed [L_SW-1:0] L_ROUND = L_SW'(longint'(1) <<< (DW - OUT_W - 1));
  assign w_sum = w_b_sh + w_m_sh + w_a_sh + L_ROUND;
`else
  assign w_sum = w_b_sh + w_m_sh + w_a_sh;
`endif

  // Clamp the sum to the DW-bit signed range.
  always_comb begin
    w_sat = w_sum;
    if (w_sum > L_SAT_MAX)      w_sat = L_SAT_MAX;
    else if (w_sum < L_SAT_MIN) w_sat = L_SAT_MIN;
  end

  assign w_word     = w_sat[DW-1:DW-OUT_W];
  assign w_end_last = (r_state == END) && (r_end_cnt == L_CW'(CLK_DIV - 1));

  // Capture the sample set on an accepted strobe.
  // NOTE: data/gain holding registers carry no reset; they are only read in
  // LOAD, which is always preceded by a capture.
  always_ff @(posedge clock_In) begin
    if (r_state == IDLE && enable) begin
      r_b  <= Data_In_bajos;
      r_m  <= Data_In_medios;
      r_a  <= Data_In_altos;
      r_gb <= gain_bajos;
      r_gm <= gain_medios;
      r_ga <= gain_altos;
    end
  end

  // State register, END hold counter, done pulse and sticky overrun.
  always_ff @(posedge clock_In) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_end_cnt <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_end_last;
      r_end_cnt <= (r_state == END && !w_end_last) ? r_end_cnt + L_CW'(1) : '0;
      if (enable && r_state != IDLE) r_overrun <= 1'b1;
    end
  end

  // Next-state logic.
  // NOTE: w_next gets a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_ser_done) w_next = END;
      END:     if (w_end_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  serializador_spi #(
    .OUT_W   (OUT_W),
    .CLK_DIV (CLK_DIV)
  ) u_serializador (
    .clk    (clock_In),
    .rst    (Reset),
    .i_load (r_state == LOAD),
    .i_word (w_word),
    .o_done (w_ser_done),
    .bus    (u_dac_bus.master)
  );

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign overrun  = r_overrun;
  assign dac_sclk = u_dac_bus.sclk;
  assign dac_cs_n = u_dac_bus.cs_n;
  assign dac_sdo  = u_dac_bus.sdo;

endmodule

// File: tb/tb_mezclador_dac.sv
// Testbench for mezclador_dac (DW=23, OUT_W=16, CLK_DIV=2). Expected words
// are queued when a frame is launched and compared when the serial monitor
// sees chip select rise after a full frame.
module tb_mezclador_dac;

  localparam int DW = 23;

  logic          clock_In = 1'b0;
  logic          Reset    = 1'b1;
  logic          enable   = 1'b0;
  logic [DW-1:0] Data_In_bajos = '0, Data_In_medios = '0, Data_In_altos = '0;
  logic [1:0]    gain_bajos = '0, gain_medios = '0, gain_altos = '0;
  logic          busy, overrun, done, dac_sclk, dac_cs_n, dac_sdo;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];

  mezclador_dac #(.DW(DW), .OUT_W(16), .CLK_DIV(2)) dut (
    .clock_In       (clock_In),
    .Reset          (Reset),
    .enable         (enable),
    .Data_In_bajos  (Data_In_bajos),
    .Data_In_medios (Data_In_medios),
    .Data_In_altos  (Data_In_altos),
    .gain_bajos     (gain_bajos),
    .gain_medios    (gain_medios),
    .gain_altos     (gain_altos),
    .busy           (busy),
    .overrun        (overrun),
    .done           (done),
    .dac_sclk       (dac_sclk),
    .dac_cs_n       (dac_cs_n),
    .dac_sdo        (dac_sdo)
  );

  mezclador_if u_mon ();
  assign u_mon.sclk = dac_sclk;
  assign u_mon.cs_n = dac_cs_n;
  assign u_mon.sdo  = dac_sdo;

  always #5 clock_In = ~clock_In;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: signed integer arithmetic with explicit clamp.
  function automatic logic [15:0] model(input logic [22:0] b, m, a, input int gb, gm, ga);
    longint vb, vm, va, s;
    vb = longint'(b); if (vb >= 64'sd4194304) vb -= 64'sd8388608;
    vm = longint'(m); if (vm >= 64'sd4194304) vm -= 64'sd8388608;
    va = longint'(a); if (va >= 64'sd4194304) va -= 64'sd8388608;
    s = (vb >>> gb) + (vm >>> gm) + (va >>> ga);
`ifdef MEZCLADOR_ROUND_EN
    s += 64;
`endif
    if (s > 64'sd4194303)  s = 64'sd4194303;
    if (s < -64'sd4194304) s = -64'sd4194304;
    return 16'((s >>> 7) & 64'hFFFF);
  endfunction

  // Serial monitor, sampled on the falling clock edge.
  logic        m_prev_sclk = 1'b0, m_prev_cs = 1'b1, m_prev_sdo = 1'b0;
  logic [15:0] m_word = '0;
  int          m_nbits = 0;
  int          sdo_viol = 0;
  bit          abort_pend = 1'b0;

  always @(negedge clock_In) begin
    if (u_mon.cs_n === 1'b1 && u_mon.sdo !== 1'b0) sdo_viol++;
    if (u_mon.cs_n === 1'b0 && m_prev_cs === 1'b0 && u_mon.sdo !== m_prev_sdo &&
        !(m_prev_sclk === 1'b1 && u_mon.sclk === 1'b0)) sdo_viol++;
    if (u_mon.cs_n === 1'b0 && m_prev_sclk === 1'b0 && u_mon.sclk === 1'b1) begin
      m_word = {m_word[14:0], u_mon.sdo};
      m_nbits++;
    end
    if (u_mon.cs_n === 1'b1 && m_prev_cs === 1'b0) begin
      if (abort_pend) begin
        abort_pend = 1'b0;
      end else begin
        check("sclk_rises", m_nbits, 16);
        if (sb_q.size() > 0) check("frame", m_word, sb_q.pop_front());
        else                 check("sb_depth", sb_q.size(), 1);
      end
      m_nbits = 0;
    end
    m_prev_sclk = u_mon.sclk;
    m_prev_cs   = u_mon.cs_n;
    m_prev_sdo  = u_mon.sdo;
  end

  task automatic drive_strobe(input logic [22:0] b, m, a, input logic [1:0] gb, gm, ga);
    Data_In_bajos = b; Data_In_medios = m; Data_In_altos = a;
    gain_bajos = gb; gain_medios = gm; gain_altos = ga;
    enable = 1'b1;
  endtask

  // Strobe for one cycle; returns #1 into the LOAD cycle.
  task automatic strobe(input logic [22:0] b, m, a, input logic [1:0] gb, gm, ga);
    @(posedge clock_In); #1;
    drive_strobe(b, m, a, gb, gm, ga);
    @(posedge clock_In); #1;
    enable = 1'b0;
  endtask

  // Cycles until done is seen (-1 on timeout); returns #1 into the done cycle.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock_In); #1;
      if (done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic frame(input string tag, input logic [22:0] b, m, a,
                       input logic [1:0] gb, gm, ga, input logic [15:0] exp);
    int n;
    sb_q.push_back(exp);
    strobe(b, m, a, gb, gm, ga);
    @(posedge clock_In); #1;
    check({tag, "_cs_entry"}, dac_cs_n, 1'b0);
    check({tag, "_msb"}, dac_sdo, exp[15]);
    wait_done(n);
    check({tag, "_done_lat"}, n + 1, 67);
    check({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock_In); #1;
    Reset = 1'b1;
    @(posedge clock_In); #1;
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    int done_seen;
    logic [22:0] rb, rm, ra;
    logic [1:0]  g0, g1, g2;

    // Reset values, and no change without enable.
    repeat (3) @(posedge clock_In);
    #1 Reset = 1'b0;
    check("rst_cs_n", dac_cs_n, 1'b1);
    check("rst_sclk", dac_sclk, 1'b0);
    check("rst_sdo",  dac_sdo, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr",  overrun, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (10) @(posedge clock_In);
    #1;
    check("idle_cs_n", dac_cs_n, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_sclk", dac_sclk, 1'b0);

    // Basic, saturation, gain and rounding frames.
    frame("basic", 23'h000100, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0, 16'h0002);
    @(posedge clock_In); #1;
    check("done_1cyc", done, 1'b0);
    frame("sat_pos", 23'h3FFFFF, 23'h3FFFFF, 23'h3FFFFF, 2'd0, 2'd0, 2'd0, 16'h7FFF);
    frame("sat_neg", 23'h400000, 23'h400000, 23'h400000, 2'd0, 2'd0, 2'd0, 16'h8000);
    frame("gain", 23'h200000, 23'h0, 23'h0, 2'd2, 2'd0, 2'd0, 16'h1000);
`ifdef MEZCLADOR_ROUND_EN
    frame("round", 23'h000040, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0, 16'h0001);
`else
    frame("round", 23'h000040, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0, 16'h0000);
`endif

    // Random mixes against the reference model.
    for (int k = 0; k < 5; k++) begin
      rb = 23'($urandom); rm = 23'($urandom); ra = 23'($urandom);
      g0 = 2'($urandom_range(3)); g1 = 2'($urandom_range(3)); g2 = 2'($urandom_range(3));
      frame("rand", rb, rm, ra, g0, g1, g2, model(rb, rm, ra, int'(g0), int'(g1), int'(g2)));
    end

    // Overrun: a second strobe 10 cycles into SHIFT is dropped.
    sb_q.push_back(16'h0002);
    strobe(23'h000100, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0);
    repeat (11) @(posedge clock_In);
    #1 drive_strobe(23'h3FFFFF, 23'h3FFFFF, 23'h3FFFFF, 2'd0, 2'd0, 2'd0);
    @(posedge clock_In); #1;
    enable = 1'b0;
    check("ovr_set", overrun, 1'b1);
    wait_done(n);
    check("ovr_lat", n, 55);
    check("ovr_hold1", overrun, 1'b1);
    frame("after_ovr", 23'h000100, 23'h000100, 23'h0, 2'd0, 2'd0, 2'd0, 16'h0004);
    check("ovr_hold2", overrun, 1'b1);
    do_reset();
    check("ovr_clr", overrun, 1'b0);

    // Abort mid-SHIFT: no done, bus back to idle next cycle.
    abort_pend = 1'b1;
    strobe(23'h123456, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock_In); #1;
      if (m_nbits >= 5) break;
    end
    check("abort_bit5", m_nbits, 5);
    Reset = 1'b1;
    @(posedge clock_In); #1;
    Reset = 1'b0;
    check("abort_cs_n", dac_cs_n, 1'b1);
    check("abort_sclk", dac_sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock_In); #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Reset wins over a simultaneous enable.
    @(posedge clock_In); #1;
    Reset = 1'b1;
    drive_strobe(23'h000100, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0);
    @(posedge clock_In); #1;
    Reset = 1'b0;
    enable = 1'b0;
    check("rst_prio_busy", busy, 1'b0);
    @(posedge clock_In); #1;
    check("rst_prio_busy2", busy, 1'b0);
    check("rst_prio_cs_n", dac_cs_n, 1'b1);

    // Back-to-back: strobe during the done cycle.
    frame("b2b_a", 23'h000100, 23'h0, 23'h0, 2'd0, 2'd0, 2'd0, 16'h0002);
    sb_q.push_back(16'h1000);
    drive_strobe(23'h200000, 23'h0, 23'h0, 2'd2, 2'd0, 2'd0);
    @(posedge clock_In); #1;
    enable = 1'b0;
    check("b2b_load_cs", dac_cs_n, 1'b1);
    check("b2b_load_busy", busy, 1'b1);
    @(posedge clock_In); #1;
    check("b2b_start", dac_cs_n, 1'b0);
    wait_done(n);
    check("b2b_lat", n, 66);

    repeat (5) @(posedge clock_In);
    #1;
    check("sdo_rules", sdo_viol, 0);
    check("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mezclador_dac.md
MEZCLADOR_DAC -- requirements
Module: mezclador_dac

Interface
REQ-001 SHALL have parameter DW, default 23, meaning the band sample width (signed two's complement).
REQ-002 SHALL have parameter OUT_W, default 16, meaning the serial DAC word width.
REQ-003 SHALL have parameter CLK_DIV, default 2, meaning the dac_sclk half-period in clock_In cycles (≥1).
REQ-004 SHALL have port clock_In, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: one-cycle sample strobe qualifying the three band inputs.
REQ-007 SHALL have ports Data_In_bajos, Data_In_medios and Data_In_altos, each input, DW bits: signed low, mid and high band samples.
REQ-008 SHALL have ports gain_bajos, gain_medios and gain_altos, each input, 2 bits: per-band arithmetic right-shift attenuation, 0 to 3.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is in progress (LOAD, SHIFT or END).
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag set when a strobe is dropped.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 SHALL have ports dac_sclk, dac_cs_n and dac_sdo, each output, 1 bit: the serial DAC interface, transmitted MSB-first.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD, SHIFT and END.
REQ-014 SHALL capture all six data/gain inputs in IDLE when enable=1 and move to LOAD on the next edge.
REQ-015 SHALL, in LOAD (1 cycle), form sum = (b>>>gb)+(m>>>gm)+(a>>>ga) at DW+2 bits, sign-extended.
REQ-016 SHALL, in LOAD, saturate sum to the range [-2^(DW-1), 2^(DW-1)-1], then take word = sat[DW-1:DW-OUT_W].
REQ-017 SHALL, on entry to SHIFT, drive dac_cs_n=0 with word MSB on dac_sdo; this occurs 2 cycles after the strobe edge.
REQ-018 SHALL idle dac_sclk low, toggle it every CLK_DIV cycles, and present data stable at each rising edge.
REQ-019 SHALL update dac_sdo only on falling edges of dac_sclk.
REQ-020 SHALL leave SHIFT after exactly OUT_W rising edges, i.e. OUT_W*2*CLK_DIV cycles, with dac_sclk ending low.
REQ-021 SHALL, in END, hold dac_cs_n=1 for CLK_DIV cycles, then return to IDLE.
REQ-022 SHALL pulse done for one cycle on that return to IDLE.
REQ-023 SHALL deassert busy in the done cycle.
REQ-024 SHALL accept an enable that coincides with the done cycle.
REQ-025 SHALL ignore enable while busy=1: the frame in flight is unaffected and overrun is set to 1.
REQ-026 SHALL hold overrun at 1 until Reset.
REQ-027 SHALL hold dac_sdo at 0 whenever dac_cs_n=1.

Reset
REQ-028 SHALL, on Reset=1 at a clock edge, force state=IDLE, dac_cs_n=1, dac_sclk=0, dac_sdo=0, busy=0, done=0 and overrun=0.
REQ-029 SHALL let Reset abort a frame mid-SHIFT with no done pulse.
REQ-030 SHALL give Reset priority over a simultaneous enable.

Configuration
REQ-031 SHALL, with MEZCLADOR_ROUND_EN defined, add 2^(DW-OUT_W-1) to sum before saturation (round half-up).
REQ-032 SHALL, without MEZCLADOR_ROUND_EN, truncate with no rounding adder; all other behaviour is identical.

Structure
REQ-033 SHALL place DW/OUT_W defaults, the state enum and the saturation limit constants in package mezclador_pkg.
REQ-034 SHALL implement the shift register, sclk divider and bit counter (LOAD word in, done out) in sub-module serializador_spi.
REQ-035 SHALL keep the capture, gain, sum and saturate logic in the top level.

Verification (DW=23, OUT_W=16, CLK_DIV=2, ROUND off unless stated)
REQ-036 SHALL verify reset values: after Reset, cs_n=1, sclk=0, sdo=0, busy=0, overrun=0, done=0; none change without enable.
REQ-037 SHALL verify a basic frame: b=0x000100, m=a=0, gains 0 -> frame 0x0002, 16 sclk rises, done 1+64+2 cycles after LOAD.
REQ-038 SHALL verify saturation:
- b=m=a=0x3FFFFF -> frame 0x7FFF;
- b=m=a=0x400000 -> frame 0x8000.
REQ-039 SHALL verify gain and rounding:
- b=0x200000, gain_bajos=2, others 0 -> frame 0x1000;
- b=0x000040 -> frame 0x0000 (ROUND off), 0x0001 (ROUND on).
REQ-040 SHALL verify overrun: a second enable 10 cycles into SHIFT leaves the frame unchanged and sets overrun=1, which holds until Reset.
REQ-041 SHALL verify abort and back-to-back:
- Reset at bit 5 -> next cycle cs_n=1, sclk=0, no done;
- enable in the done cycle -> new frame starts 2 cycles later.
